sw_readback_unit: RTL and testbench

SW_READBACK_UNIT -- requirements
Module: sw_readback_unit

---
 rtl/sw_readback_unit_if.sv | 31 +++
 rtl/sw_readback_unit.sv | 176 +++++++++++++++++
 tb/tb_sw_readback_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sw_readback_unit_if.sv
// Bundle of the software read port, the FPU read channel and the SIMD lane inputs.
// The slave modport is the readback unit; the master modport is its environment.
interface sw_readback_unit_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4
);
  logic                        fpu_simd;
  logic                        rd_req;
  logic [31:0]                 rd_addr;
  logic                        rd_ready;
  logic                        rd_busy;
  logic                        rd_valid;
  logic [DATA_W-1:0]           rd_data;
  logic                        rd_err;
  logic                        fpu_rd_req;
  logic [31:0]                 fpu_rd_addr;
  logic [DATA_W-1:0]           fpu_rdata;
  logic                        fpu_rvalid;
  logic [NUM_LANES*DATA_W-1:0] simd_output;
  logic                        simd_busy;

  modport slave (
    input  fpu_simd, rd_req, rd_addr, rd_ready, fpu_rdata, fpu_rvalid, simd_output, simd_busy,
    output rd_busy, rd_valid, rd_data, rd_err, fpu_rd_req, fpu_rd_addr
  );

  modport master (
    output fpu_simd, rd_req, rd_addr, rd_ready, fpu_rdata, fpu_rvalid, simd_output, simd_busy,
    input  rd_busy, rd_valid, rd_data, rd_err, fpu_rd_req, fpu_rd_addr
  );
endinterface

// File: rtl/sw_readback_unit.sv
// Software readback unit: decodes a read address to the FPU register channel or a SIMD
// output lane, waits (bounded) for the data, and holds one registered response.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no read outstanding, accepts rd_req
// WAIT_FPU  | fpu_rd_req asserted, waiting for fpu_rvalid or timeout
// WAIT_SIMD | SIMD lanes busy, waiting for simd_busy to drop or timeout
// RESP      | rd_valid asserted, response held until rd_ready
module sw_readback_unit #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_LANES   = 4,
  parameter logic [31:0] CMD_ADDR    = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0110,
  parameter logic [31:0] OUT_BASE    = 32'h0000_0130,
  parameter int          TIMEOUT     = 16
) (
  input logic                clk,
  input logic                rst,
  sw_readback_unit_if.slave  bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FPU  = 2'd1,
    WAIT_SIMD = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                busy_q;
  logic                valid_q;
  logic                err_q;
  logic [DATA_W-1:0]   data_q;
  logic                fpu_req_q;
  logic [31:0]         fpu_addr_q;

  logic                dec_fpu;
  logic                dec_simd;
  logic [LANE_W-1:0]   dec_lane;
  logic                timeout_hit;

  function automatic logic [DATA_W-1:0] pick_lane(
    input logic [NUM_LANES*DATA_W-1:0] lanes,
    input logic [LANE_W-1:0]           idx
  );
    logic [DATA_W-1:0] sel;
    sel = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (idx == LANE_W'(k)) sel = lanes[k*DATA_W +: DATA_W];
    end
    return sel;
  endfunction

  // Output addresses go to the FPU when fpu_simd is low; the choice is frozen at accept.
  always_comb begin
    dec_fpu  = 1'b0;
    dec_simd = 1'b0;
    dec_lane = '0;
    if (bus.rd_addr == CMD_ADDR || bus.rd_addr == STATUS_ADDR) begin
      dec_fpu = 1'b1;
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.rd_addr == OUT_BASE + 32'(4 * k)) begin
        dec_lane = LANE_W'(k);
        if (bus.fpu_simd) dec_simd = 1'b1;
        else              dec_fpu  = 1'b1;
      end
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane_q     <= '0;
      wait_cnt   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      fpu_req_q  <= 1'b0;
      fpu_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            fpu_addr_q <= bus.rd_addr;
            lane_q     <= dec_lane;
            wait_cnt   <= '0;
            busy_q     <= 1'b1;
            if (dec_fpu) begin
              fpu_req_q <= 1'b1;
              state     <= WAIT_FPU;
            end else if (dec_simd) begin
              if (bus.simd_busy) begin
                state <= WAIT_SIMD;
              end else begin
                data_q  <= pick_lane(bus.simd_output, dec_lane);
                err_q   <= 1'b0;
                valid_q <= 1'b1;
                state   <= RESP;
              end
            end else begin
              data_q  <= '0;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state   <= RESP;
            end
          end
        end

        // Completion is checked before timeout so a last-cycle response still succeeds.
        WAIT_FPU: begin
          if (bus.fpu_rvalid) begin
            data_q    <= bus.fpu_rdata;
            err_q     <= 1'b0;
            valid_q   <= 1'b1;
            fpu_req_q <= 1'b0;
            state     <= RESP;
          end else if (timeout_hit) begin
            data_q    <= '0;
            err_q     <= 1'b1;
            valid_q   <= 1'b1;
            fpu_req_q <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WAIT_SIMD: begin
          if (!bus.simd_busy) begin
            data_q  <= pick_lane(bus.simd_output, lane_q);
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= RESP;
          end else if (timeout_hit) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (bus.rd_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_busy     = busy_q;
  assign bus.rd_valid    = valid_q;
  assign bus.rd_data     = data_q;
  assign bus.rd_err      = err_q;
  assign bus.fpu_rd_req  = fpu_req_q;
  assign bus.fpu_rd_addr = fpu_addr_q;

endmodule

// File: tb/tb_sw_readback_unit.sv
// Directed bench for sw_readback_unit: SIMD, FPU, unmapped, timeout, hold and reset cases
// with hand-computed expected values.
module tb_sw_readback_unit;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  sw_readback_unit_if #(.DATA_W(32), .NUM_LANES(4)) bus ();

  sw_readback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic release_resp();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int n;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.fpu_simd    = 1'b0;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = 32'h0;
    bus.rd_ready    = 1'b0;
    bus.fpu_rdata   = 32'h0;
    bus.fpu_rvalid  = 1'b0;
    bus.simd_busy   = 1'b0;
    bus.simd_output = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    tick();
    tick();
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_busy", bus.rd_busy, 0);
    chk("rst_data", bus.rd_data, 0);
    chk("rst_err", bus.rd_err, 0);
    chk("rst_fpureq", bus.fpu_rd_req, 0);
    chk("rst_fpuaddr", bus.fpu_rd_addr, 0);
    rst = 1'b0;
    tick();

    // SIMD lane 2, lanes stable
    bus.fpu_simd = 1'b1;
    bus.rd_addr  = 32'h138;
    bus.rd_req   = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("simd_valid", bus.rd_valid, 1);
    chk("simd_data", bus.rd_data, 32'hA5A5_0002);
    chk("simd_err", bus.rd_err, 0);
    chk("simd_fpureq", bus.fpu_rd_req, 0);
    release_resp();
    chk("simd_idle_valid", bus.rd_valid, 0);
    chk("simd_idle_busy", bus.rd_busy, 0);

    // FPU status read, data on 3rd wait cycle
    bus.rd_addr = 32'h110;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("fpu_req_c1", bus.fpu_rd_req, 1);
    chk("fpu_addr", bus.fpu_rd_addr, 32'h110);
    chk("fpu_busy", bus.rd_busy, 1);
    chk("fpu_novalid", bus.rd_valid, 0);
    tick();
    chk("fpu_req_c2", bus.fpu_rd_req, 1);
    tick();
    chk("fpu_req_c3", bus.fpu_rd_req, 1);
    bus.fpu_rdata  = 32'h0000_00F1;
    bus.fpu_rvalid = 1'b1;
    tick();
    bus.fpu_rvalid = 1'b0;
    chk("fpu_req_drop", bus.fpu_rd_req, 0);
    chk("fpu_valid", bus.rd_valid, 1);
    chk("fpu_data", bus.rd_data, 32'h0000_00F1);
    chk("fpu_err", bus.rd_err, 0);
    release_resp();

    // Output address in FPU mode, no response -> timeout after 16 wait cycles
    bus.fpu_simd = 1'b0;
    bus.rd_addr  = 32'h130;
    bus.rd_req   = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("to_fpureq", bus.fpu_rd_req, 1);
    n = 0;
    while (!bus.rd_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_valid", bus.rd_valid, 1);
    chk("to_data", bus.rd_data, 0);
    chk("to_err", bus.rd_err, 1);
    release_resp();

    // Unmapped read, response held while rd_ready low; stray requests and fpu_rvalid ignored
    bus.rd_addr = 32'h0000_0200;
    bus.rd_req  = 1'b1;
    tick();
    chk("um_valid", bus.rd_valid, 1);
    chk("um_data", bus.rd_data, 0);
    chk("um_err", bus.rd_err, 1);
    bus.fpu_simd   = 1'b1;
    bus.rd_addr    = 32'h138;
    bus.fpu_rdata  = 32'hDEAD_BEEF;
    bus.fpu_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("um_hold_valid", bus.rd_valid, 1);
      chk("um_hold_data", bus.rd_data, 0);
      chk("um_hold_err", bus.rd_err, 1);
    end
    bus.fpu_rvalid = 1'b0;
    bus.rd_ready   = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("exit_no_accept_valid", bus.rd_valid, 0);
    chk("exit_no_accept_busy", bus.rd_busy, 0);
    tick();
    bus.rd_req = 1'b0;
    chk("next_accept_valid", bus.rd_valid, 1);
    chk("next_accept_data", bus.rd_data, 32'hA5A5_0002);
    release_resp();

    // SIMD lane 0 with lanes busy for 4 cycles, mode flipped mid-wait
    bus.fpu_simd         = 1'b1;
    bus.simd_busy        = 1'b1;
    bus.simd_output[31:0] = 32'h1111_0000;
    bus.rd_addr          = 32'h130;
    bus.rd_req           = 1'b1;
    tick();
    bus.rd_req   = 1'b0;
    bus.fpu_simd = 1'b0;
    chk("sb_busy", bus.rd_busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("sb_fpureq", bus.fpu_rd_req, 0);
      chk("sb_novalid", bus.rd_valid, 0);
      tick();
    end
    bus.simd_output[31:0] = 32'h2222_0000;
    bus.simd_busy         = 1'b0;
    tick();
    chk("sb_valid", bus.rd_valid, 1);
    chk("sb_data", bus.rd_data, 32'h2222_0000);
    chk("sb_err", bus.rd_err, 0);
    chk("sb_fpureq_end", bus.fpu_rd_req, 0);
    release_resp();

    // Completion on the final (16th) wait cycle beats timeout
    bus.rd_addr = 32'h0;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("race_novalid", bus.rd_valid, 0);
    bus.fpu_rdata  = 32'h0000_C0DE;
    bus.fpu_rvalid = 1'b1;
    tick();
    bus.fpu_rvalid = 1'b0;
    chk("race_valid", bus.rd_valid, 1);
    chk("race_data", bus.rd_data, 32'h0000_C0DE);
    chk("race_err", bus.rd_err, 0);
    release_resp();

    // Reset during WAIT_FPU, late fpu_rvalid ignored
    bus.rd_addr = 32'h110;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.fpu_rdata  = 32'h0000_0055;
    bus.fpu_rvalid = 1'b1;
    tick();
    tick();
    bus.fpu_rvalid = 1'b0;
    chk("mr_valid", bus.rd_valid, 0);
    chk("mr_busy", bus.rd_busy, 0);
    chk("mr_data", bus.rd_data, 0);
    chk("mr_err", bus.rd_err, 0);
    chk("mr_fpureq", bus.fpu_rd_req, 0);
    chk("mr_fpuaddr", bus.fpu_rd_addr, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
